sm4_decryptor: RTL and testbench

Iterative SM4 block decryptor: the inverse-direction companion of the team's SM4 encryptor, sharing `sm4_encryptor_pkg` constants.
- Loads a 128-bit master key and expands it once into 32 stored round keys, one per cycle.
- Decrypts 128-bit ciphertext blocks one round per cycle, applying the round keys in reverse order (rk31 down to rk0).
- Sits between a ciphertext source and a plaintext sink, with valid/ready in and valid/yumi out.

---
 rtl/sm4_encryptor_pkg.sv | 72 +++++++
 rtl/sm4_decryptor_if.sv | 26 ++
 rtl/sm4_round_func.sv | 29 ++
 rtl/sm4_decryptor.sv | 129 ++++++++++++
 tb/tb_sm4_decryptor.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sm4_encryptor_pkg.sv
// Shared SM4 constants and helpers for the encryptor/decryptor pair.
// Contents: block/word/round-count widths, FK mask, CK round constants, the
// 256-entry S-box, the decryptor state type and a 32-bit rotate-left helper.
package sm4_encryptor_pkg;

  localparam int unsigned group_size_p   = 128;
  localparam int unsigned word_width_p   = 32;
  localparam int unsigned turn_key_num_p = 32;

  // FK, XORed onto the master key before expansion
  localparam logic [127:0] key_xor_mask_p = 128'ha3b1bac6_56aa3350_677d9197_b27022dc;

  // CK, one constant per key-expansion round
  localparam logic [31:0] key_aux_p [turn_key_num_p] = '{
    32'h00070e15, 32'h1c232a31, 32'h383f464d, 32'h545b6269,
    32'h70777e85, 32'h8c939aa1, 32'ha8afb6bd, 32'hc4cbd2d9,
    32'he0e7eef5, 32'hfc030a11, 32'h181f262d, 32'h343b4249,
    32'h50575e65, 32'h6c737a81, 32'h888f969d, 32'ha4abb2b9,
    32'hc0c7ced5, 32'hdce3eaf1, 32'hf8ff060d, 32'h141b2229,
    32'h30373e45, 32'h4c535a61, 32'h686f767d, 32'h848b9299,
    32'ha0a7aeb5, 32'hbcc3cad1, 32'hd8dfe6ed, 32'hf4fb0209,
    32'h10171e25, 32'h2c333a41, 32'h484f565d, 32'h646b7279
  };

  localparam logic [7:0] sbox_p [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7,
    8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3,
    8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a,
    8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95,
    8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba,
    8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b,
    8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2,
    8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52,
    8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5,
    8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55,
    8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60,
    8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f,
    8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f,
    8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd,
    8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e,
    8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20,
    8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  typedef enum logic [2:0] {
    StIdle,
    StKeyExp,
    StReady,
    StDec,
    StDone
  } sm4_dec_state_e;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input int unsigned n);
    return (x << n) | (x >> (32 - n));
  endfunction

endpackage

// File: rtl/sm4_decryptor_if.sv
// Key/ciphertext/plaintext handshake bundle for sm4_decryptor.
// master: drives key_v_i, key_i, v_i, data_i, yumi_i; slave: drives key_ready_o,
// ready_o, v_o, data_o. Signal names follow the decryptor port list.
interface sm4_decryptor_if;
  import sm4_encryptor_pkg::*;

  logic                    key_v_i;
  logic [group_size_p-1:0] key_i;
  logic                    key_ready_o;
  logic                    v_i;
  logic [group_size_p-1:0] data_i;
  logic                    ready_o;
  logic                    v_o;
  logic [group_size_p-1:0] data_o;
  logic                    yumi_i;

  modport master (
    output key_v_i, key_i, v_i, data_i, yumi_i,
    input  key_ready_o, ready_o, v_o, data_o
  );

  modport slave (
    input  key_v_i, key_i, v_i, data_i, yumi_i,
    output key_ready_o, ready_o, v_o, data_o
  );
endinterface

// File: rtl/sm4_round_func.sv
// Combinational SM4 round transform: byte-wise S-box (tau) followed by the
// linear mix. key_mode_i=1 selects L' (key schedule), 0 selects L (cipher).
// Ports: data_i (32b in), key_mode_i (L'/L select), data_o (32b out).
module sm4_round_func
  import sm4_encryptor_pkg::*;
(
  input  logic [word_width_p-1:0] data_i,
  input  logic                    key_mode_i,
  output logic [word_width_p-1:0] data_o
);

  logic [word_width_p-1:0] tau;

  always_comb begin
    tau = '0;
    for (int k = 0; k < 4; k++) begin
      tau[8*k +: 8] = sbox_p[data_i[8*k +: 8]];
    end
  end

  always_comb begin
    if (key_mode_i) begin
      data_o = tau ^ rotl32(tau, 13) ^ rotl32(tau, 23);
    end else begin
      data_o = tau ^ rotl32(tau, 2) ^ rotl32(tau, 10) ^ rotl32(tau, 18) ^ rotl32(tau, 24);
    end
  end

endmodule

// File: rtl/sm4_decryptor.sv
// Iterative SM4 block decryptor. A master key is expanded once into a 32-entry
// round-key file (one key per cycle); each ciphertext block then takes 32
// rounds using the keys in reverse order.
// Ports: clk_i, reset_i (async, active-high), bus (sm4_decryptor_if.slave):
// key_v_i/key_i/key_ready_o key load, v_i/data_i/ready_o ciphertext in,
// v_o/data_o/yumi_i plaintext out.
module sm4_decryptor
  import sm4_encryptor_pkg::*;
(
  input  logic           clk_i,
  input  logic           reset_i,
  sm4_decryptor_if.slave bus
);

  sm4_dec_state_e state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  // Sliding 4-word window: K[i..i+3] during KEYEXP, X[j..j+3] during DEC.
  logic [group_size_p-1:0] win_q, win_d;
  logic [group_size_p-1:0] data_q, data_d;
  logic                    v_q, v_d;
  logic                    keys_ok_q, keys_ok_d;
  logic [word_width_p-1:0] rk_q [turn_key_num_p];
  logic                    rk_we;

  logic                    key_mode, last_round, key_fire, data_fire;
  logic [word_width_p-1:0] rf_in, rf_out, new_word;

  assign key_mode   = (state_q == StKeyExp);
  assign last_round = (cnt_q == 5'd31);

  assign bus.key_ready_o = (state_q == StIdle) || (state_q == StReady);
  // A pending key always beats a pending block.
  assign bus.ready_o     = (state_q == StReady) && keys_ok_q && !bus.key_v_i;
  assign bus.v_o         = v_q;
  assign bus.data_o      = data_q;

  assign key_fire  = bus.key_v_i && bus.key_ready_o;
  assign data_fire = bus.v_i && bus.ready_o;

  // ~cnt_q == 31 - cnt_q: decryption walks the key file backwards.
  assign rf_in = win_q[95:64] ^ win_q[63:32] ^ win_q[31:0] ^
                 (key_mode ? key_aux_p[cnt_q] : rk_q[~cnt_q]);

  sm4_round_func u_round_func (
    .data_i     (rf_in),
    .key_mode_i (key_mode),
    .data_o     (rf_out)
  );

  assign new_word = win_q[127:96] ^ rf_out;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    win_d     = win_q;
    data_d    = data_q;
    v_d       = v_q;
    keys_ok_d = keys_ok_q;
    rk_we     = 1'b0;
    unique case (state_q)
      StIdle, StReady: begin
        if (key_fire) begin
          win_d     = bus.key_i ^ key_xor_mask_p;
          cnt_d     = 5'd0;
          keys_ok_d = 1'b0;
          state_d   = StKeyExp;
        end else if (data_fire) begin
          win_d   = bus.data_i;
          cnt_d   = 5'd0;
          state_d = StDec;
        end
      end
      StKeyExp: begin
        rk_we = 1'b1;
        win_d = {win_q[95:0], new_word};
        cnt_d = cnt_q + 5'd1;
        if (last_round) begin
          cnt_d     = 5'd0;
          keys_ok_d = 1'b1;
          state_d   = StReady;
        end
      end
      StDec: begin
        win_d = {win_q[95:0], new_word};
        cnt_d = cnt_q + 5'd1;
        if (last_round) begin
          // Output is the reversed final window {X35, X34, X33, X32}.
          data_d  = {new_word, win_q[31:0], win_q[63:32], win_q[95:64]};
          v_d     = 1'b1;
          cnt_d   = 5'd0;
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.yumi_i) begin
          v_d     = 1'b0;
          state_d = StReady;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      cnt_q     <= 5'd0;
      win_q     <= '0;
      data_q    <= '0;
      v_q       <= 1'b0;
      keys_ok_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      data_q    <= data_d;
      v_q       <= v_d;
      keys_ok_q <= keys_ok_d;
    end
  end

  // Key file needs no reset: keys_ok_q gates its use.
  always_ff @(posedge clk_i) begin
    if (rk_we) begin
      rk_q[cnt_q] <= new_word;
    end
  end

endmodule

// File: tb/tb_sm4_decryptor.sv
// Self-checking bench for sm4_decryptor: vector table, hand-written corner
// sequences (backpressure, key/data collision, mid-decrypt reset) and random
// key/plaintext pairs checked against a behavioural SM4 model.
module tb_sm4_decryptor;
  import sm4_encryptor_pkg::*;

  logic clk_i;
  logic reset_i;
  sm4_decryptor_if bus ();

  sm4_decryptor dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] StdKey = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] StdCt  = 128'h681edf34d206965e86b3e94f536e4246;

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau_f(input logic [31:0] x);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = sbox_p[x[8*k +: 8]];
    return r;
  endfunction

  // dec=0 encrypts, dec=1 decrypts
  function automatic logic [127:0] ref_crypt(input logic [127:0] key, input logic [127:0] blk,
                                             input bit dec);
    logic [31:0] fk [4];
    logic [31:0] k [36];
    logic [31:0] rk [32];
    logic [31:0] x [36];
    logic [31:0] ck, b;
    fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350; fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
    for (int i = 0; i < 4; i++) begin
      k[i] = key[127 - 32*i -: 32] ^ fk[i];
      x[i] = blk[127 - 32*i -: 32];
    end
    for (int i = 0; i < 32; i++) begin
      ck = '0;
      for (int j = 0; j < 4; j++) ck = {ck[23:0], 8'(((4 * i + j) * 7) % 256)};
      b = tau_f(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      k[i+4] = k[i] ^ b ^ rl(b, 13) ^ rl(b, 23);
      rk[i] = k[i+4];
    end
    for (int j = 0; j < 32; j++) begin
      b = tau_f(x[j+1] ^ x[j+2] ^ x[j+3] ^ (dec ? rk[31-j] : rk[j]));
      x[j+4] = x[j] ^ b ^ rl(b, 2) ^ rl(b, 10) ^ rl(b, 18) ^ rl(b, 24);
    end
    return {x[35], x[34], x[33], x[32]};
  endfunction

  // ---------------- driver tasks ----------------
  // Loads a key and checks the 32-cycle expansion latency.
  task automatic send_key(input logic [127:0] k);
    int n = 0;
    while (!bus.key_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("key_ready_wait", 128'(bus.key_ready_o), 128'd1);
    bus.key_v_i = 1'b1;
    bus.key_i   = k;
    @(negedge clk_i);
    bus.key_v_i = 1'b0;
    check("key_ready_in_keyexp", 128'(bus.key_ready_o), 128'd0);
    n = 0;
    while (!bus.ready_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    check("keyexp_latency", 128'(n), 128'd32);
  endtask

  // Decrypts one block; holds off yumi_i for 'delay' cycles checking stability.
  task automatic decrypt(input logic [127:0] ct, input int delay,
                         output logic [127:0] pt, output int lat);
    int n = 0;
    while (!bus.ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("ready_wait", 128'(bus.ready_o), 128'd1);
    bus.v_i    = 1'b1;
    bus.data_i = ct;
    @(negedge clk_i);
    bus.v_i = 1'b0;
    lat = 0;
    while (!bus.v_o && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    pt = bus.data_o;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk_i);
      check("hold_v_o", 128'(bus.v_o), 128'd1);
      check("hold_data_o", bus.data_o, pt);
      check("hold_ready_o", 128'(bus.ready_o), 128'd0);
    end
    bus.yumi_i = 1'b1;
    @(negedge clk_i);
    bus.yumi_i = 1'b0;
    check("v_o_after_yumi", 128'(bus.v_o), 128'd0);
    check("ready_after_yumi", 128'(bus.ready_o), 128'd1);
  endtask

  vec_t vecs [4];
  logic [127:0] got, k2, pt2, ct2, k, pt;
  int lat;

  initial begin
    reset_i     = 1'b1;
    bus.key_v_i = 1'b0;
    bus.key_i   = '0;
    bus.v_i     = 1'b0;
    bus.data_i  = '0;
    bus.yumi_i  = 1'b0;

    vecs[0] = '{key: StdKey, ct: StdCt, pt: StdKey};
    vecs[1] = '{key: '0, ct: ref_crypt('0, '0, 1'b0), pt: '0};
    vecs[2] = '{key: '1, ct: ref_crypt('1, StdKey, 1'b0), pt: StdKey};
    vecs[3] = '{key: StdCt, ct: ref_crypt(StdCt, 128'h1, 1'b0), pt: 128'h1};

    repeat (3) @(negedge clk_i);
    check("rst_v_o", 128'(bus.v_o), 128'd0);
    check("rst_ready_o", 128'(bus.ready_o), 128'd0);
    check("rst_key_ready_o", 128'(bus.key_ready_o), 128'd1);
    check("rst_data_o", bus.data_o, 128'd0);
    reset_i = 1'b0;
    @(negedge clk_i);

    // Standard vector: key schedule endpoints and exact latency
    send_key(StdKey);
    check("rk0", 128'(dut.rk_q[0]), 128'hf12186f9);
    check("rk31", 128'(dut.rk_q[31]), 128'h9124a012);
    decrypt(StdCt, 0, got, lat);
    check("std_latency", 128'(lat), 128'd32);
    check("std_plaintext", got, StdKey);

    // Table of vectors
    for (int i = 0; i < 4; i++) begin
      send_key(vecs[i].key);
      decrypt(vecs[i].ct, i, got, lat);
      check($sformatf("vec%0d_pt", i), got, vecs[i].pt);
    end

    // Backpressure: 10 cycles without yumi_i, then a second block
    send_key(StdKey);
    decrypt(StdCt, 10, got, lat);
    check("bp_first", got, StdKey);
    pt2 = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    decrypt(ref_crypt(StdKey, pt2, 1'b0), 0, got, lat);
    check("bp_second", got, pt2);

    // Key and data offered together in READY: key wins
    k2  = 128'h00112233_44556677_8899aabb_ccddeeff;
    pt2 = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
    ct2 = ref_crypt(k2, pt2, 1'b0);
    bus.key_v_i = 1'b1;
    bus.key_i   = k2;
    bus.v_i     = 1'b1;
    bus.data_i  = ct2;
    #1;
    check("collide_ready_o", 128'(bus.ready_o), 128'd0);
    check("collide_key_ready_o", 128'(bus.key_ready_o), 128'd1);
    @(negedge clk_i);
    bus.key_v_i = 1'b0;
    bus.v_i     = 1'b0;
    lat = 0;
    while (!bus.ready_o && lat < 40) begin
      @(negedge clk_i);
      lat++;
    end
    check("collide_keyexp_latency", 128'(lat), 128'd32);
    check("collide_no_data_v_o", 128'(bus.v_o), 128'd0);
    decrypt(ct2, 1, got, lat);
    check("collide_new_key_pt", got, pt2);

    // Reset during decrypt round 15
    bus.v_i    = 1'b1;
    bus.data_i = ct2;
    @(negedge clk_i);
    bus.v_i = 1'b0;
    repeat (15) @(negedge clk_i);
    #2 reset_i = 1'b1;
    #1;
    check("midrst_v_o", 128'(bus.v_o), 128'd0);
    check("midrst_ready_o", 128'(bus.ready_o), 128'd0);
    check("midrst_key_ready_o", 128'(bus.key_ready_o), 128'd1);
    check("midrst_data_o", bus.data_o, 128'd0);
    @(negedge clk_i);
    reset_i    = 1'b0;
    bus.v_i    = 1'b1;
    bus.data_i = ct2;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check("idle_ready_o", 128'(bus.ready_o), 128'd0);
      check("idle_v_o", 128'(bus.v_o), 128'd0);
    end
    bus.v_i = 1'b0;
    send_key(k2);
    decrypt(ct2, 0, got, lat);
    check("post_rst_pt", got, pt2);

    // Random pairs
    for (int r = 0; r < 200; r++) begin
      k  = {$urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
      send_key(k);
      decrypt(ref_crypt(k, pt, 1'b0), int'($urandom_range(0, 5)), got, lat);
      check($sformatf("rand%0d_pt", r), got, pt);
      check($sformatf("rand%0d_latency", r), 128'(lat), 128'd32);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
